processador_multiciclo_gen: RTL and testbench
=============================================

# processador_multiciclo_gen

Parametrised successor of the multicycle processor. It keeps the same bus-based datapath: 2^RSEL_W general registers, A, G, IR, a shared bus and a step counter. The data width and register count are generic, and the ISA adds AND, SLT and an explicit no-op. It sits where the current processor sits, driven by DIN/Run from the instruction source, and exposes Done, BusWires and Rx_data/Ry_data for observation.

## Interface
- DATA_W, 16, width of DIN, bus, registers, A and G; must satisfy DATA_W >= 3+2*RSEL_W
- RSEL_W, 3, register-select field width; register count is 2^RSEL_W (1..3 supported)
- Clock  in  1  single clock, all state updates on rising edge
- Resetn  in  1  asynchronous, active-low reset
- Run  in  1  start request, sampled only in T0
- DIN  in  DATA_W  instruction word (T0) or immediate (mvi, T1)
- Done  out  1  high during the final step of an instruction
- BusWires  out  DATA_W  current bus value
- Rx_data  out  DATA_W  contents of the register selected by IR.Rx
- Ry_data  out  DATA_W  contents of the register selected by IR.Ry
- Zflag, Cflag  out  1 each  present only with PROC_FLAGS_EN

## Operation
- IR width IR_W = 3+2*RSEL_W, loaded from DIN[IR_W-1:0]. Fields: opcode = IR[IR_W-1:IR_W-3], Rx = next RSEL_W bits, Ry = low RSEL_W bits.
- Step counter Tstep holds 2 bits (T0..T3) and returns to T0 after every Done step.
- T0 (fetch): if Run=1, IR <= DIN and Tstep -> T1. If Run=0, hold in T0 and leave IR unchanged. Bus drives 0.
- 000 mv: T1 bus=R[Ry], R[Rx] <= bus, Done.
- 001 mvi: T1 bus=DIN, R[Rx] <= bus, Done.
- 100 mvnz: T1 bus=R[Ry]; R[Rx] <= bus only if G != 0; Done either way.
- 010 add, 011 sub, 101 and, 110 slt follow the same three steps:
  - T1: bus=R[Rx], A <= bus.
  - T2: bus=R[Ry], G <= A op bus.
  - T3: bus=G, R[Rx] <= bus, Done.
- ALU results:
  - add/sub: modulo 2^DATA_W.
  - and: bitwise.
  - slt: unsigned compare; G = 1 if A < bus, else 0, zero-extended.
- 111 nop: T1 Done, no register or A/G write, bus=0.
- Run is ignored outside T0. An instruction in progress always completes.
- Only one bus source is active per step. The bus is 0 in any step with no source.
- Rx_data/Ry_data are combinational reads of R[IR.Rx]/R[IR.Ry].
- Rx == Ry is legal:
  - mv Rx,Rx leaves the register unchanged.
  - sub Rx,Rx gives 0.

## Timing
- Resetn low, asynchronously: all R, A, G, IR = 0, Tstep = T0, Done = 0, BusWires = 0 (flags = 0). Reset mid-instruction aborts it, with no partial register write after release.
- Latency from the Run-sampled edge to the Done step:
  - mv, mvi, mvnz, nop: 1 cycle (Done in T1).
  - alu ops: 3 cycles (Done in T3).
- Done is combinational from Tstep/opcode and is high for exactly one cycle per instruction. The destination write occurs on the rising edge that ends the Done cycle.
- For mvi, DIN must hold the immediate during T1. It is sampled on the edge ending T1.
- Back-to-back: with Run held high, the next fetch is in the cycle after Done.

## Configuration
- PROC_FLAGS_EN defined:
  - Zflag/Cflag ports exist, updated on the same edge as G writes; they hold otherwise.
  - Z = (new G == 0).
  - C = carry-out for add, borrow (A < bus) for sub, 0 for and/slt.
- PROC_FLAGS_EN undefined: the ports and flag registers are absent. All other behaviour is identical.

## Test plan
- Reset, then mv R0,R1 with R0=11, R1=10 -> Done in T1, R0=10, R1=10, Tstep back to 0.
- mvi R0 with DIN=5 in T1 -> BusWires=5 in T1, R0=5, Done after 1 cycle. Also: Run=0 at T0 -> Tstep stays 0 and IR unchanged.
- sub R1,R0 with R1=10, R0=5 -> A=10 after T1, G=5 after T2, R1=5 at T3 with Done.
- sub R1,R0 with R1=5, R0=10 -> R1=0xFFFB (DATA_W=16). With PROC_FLAGS_EN: C=1, Z=0.
- Conditional move and slt:
  - mvnz R0,R1 with G=0 -> R0 stays 11.
  - mvnz R0,R1 with G=5 -> R0=10.
  - slt R2,R3 with R2=3, R3=7 -> R2=1.
- Parametrised build and reset handling:
  - DATA_W=8, RSEL_W=2: add R3,R2 with R3=200, R2=100 -> R3=44; with PROC_FLAGS_EN, C=1.
  - Resetn pulsed low during T2 of an add -> all state 0 immediately, no write after release.

Source files
------------

// File: rtl/processador_multiciclo_gen.sv
// rtl/processador_multiciclo_gen.sv - parametrised bus-based multicycle processor (optional Z/C flags: PROC_FLAGS_EN)
module processador_multiciclo_gen #(
    parameter int DATA_W = 16,
    parameter int RSEL_W = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              Done,
    output logic [DATA_W-1:0] BusWires,
    output logic [DATA_W-1:0] Rx_data,
    output logic [DATA_W-1:0] Ry_data
`ifdef PROC_FLAGS_EN
    ,
    output logic              Zflag,
    output logic              Cflag
`endif
);
    localparam int IR_W = 3 + 2 * RSEL_W;
    localparam int NREG = 1 << RSEL_W;

    typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100,
        OP_AND  = 3'b101,
        OP_SLT  = 3'b110,
        OP_NOP  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {BUS_NONE, BUS_RX, BUS_RY, BUS_DIN, BUS_G} bus_sel_t;

    tstep_t             tstep;
    tstep_t             tstep_next;
    logic [IR_W-1:0]    ir;
    logic [DATA_W-1:0]  regs [NREG];
    logic [DATA_W-1:0]  reg_a;
    logic [DATA_W-1:0]  reg_g;
    opcode_t            opcode;
    logic [RSEL_W-1:0]  rx;
    logic [RSEL_W-1:0]  ry;

    logic               ir_we;
    logic               a_we;
    logic               g_we;
    logic               r_we;
    bus_sel_t           bus_sel;

    logic [DATA_W-1:0]  add_result;
    logic [DATA_W-1:0]  alu_result;
    logic               a_lt_b;

    assign opcode = opcode_t'(ir[IR_W-1 -: 3]);
    assign rx     = ir[2*RSEL_W-1 -: RSEL_W];
    assign ry     = ir[RSEL_W-1:0];

    // Instruction bits above the IR field carry no meaning and are discarded.
    generate
        if (DATA_W > IR_W) begin : g_din_hi
            logic unused_din_hi;
            assign unused_din_hi = ^DIN[DATA_W-1:IR_W];
        end
    endgenerate

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tstep <= T0;
        end else begin
            tstep <= tstep_next;
        end
    end

    always_comb begin
        tstep_next = tstep;
        ir_we      = 1'b0;
        a_we       = 1'b0;
        g_we       = 1'b0;
        r_we       = 1'b0;
        Done       = 1'b0;
        bus_sel    = BUS_NONE;
        case (tstep)
            T0: begin
                if (Run) begin
                    ir_we      = 1'b1;
                    tstep_next = T1;
                end
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        bus_sel    = BUS_RY;
                        r_we       = 1'b1;
                        Done       = 1'b1;
                        tstep_next = T0;
                    end
                    OP_MVI: begin
                        bus_sel    = BUS_DIN;
                        r_we       = 1'b1;
                        Done       = 1'b1;
                        tstep_next = T0;
                    end
                    OP_MVNZ: begin
                        bus_sel    = BUS_RY;
                        r_we       = (reg_g != '0);
                        Done       = 1'b1;
                        tstep_next = T0;
                    end
                    OP_NOP: begin
                        Done       = 1'b1;
                        tstep_next = T0;
                    end
                    default: begin
                        bus_sel    = BUS_RX;
                        a_we       = 1'b1;
                        tstep_next = T2;
                    end
                endcase
            end
            T2: begin
                bus_sel    = BUS_RY;
                g_we       = 1'b1;
                tstep_next = T3;
            end
            T3: begin
                bus_sel    = BUS_G;
                r_we       = 1'b1;
                Done       = 1'b1;
                tstep_next = T0;
            end
            default: tstep_next = T0;
        endcase
    end

    always_comb begin
        BusWires = '0;
        case (bus_sel)
            BUS_RX:  BusWires = regs[rx];
            BUS_RY:  BusWires = regs[ry];
            BUS_DIN: BusWires = DIN;
            BUS_G:   BusWires = reg_g;
            default: BusWires = '0;
        endcase
    end

    assign a_lt_b = (reg_a < BusWires);

`ifdef PROC_FLAGS_EN
    logic [DATA_W:0] sum_ext;
    logic            alu_carry;

    assign sum_ext    = {1'b0, reg_a} + {1'b0, BusWires};
    assign add_result = sum_ext[DATA_W-1:0];

    // Carry for add, borrow for sub; logical ops never produce one.
    always_comb begin
        alu_carry = 1'b0;
        case (opcode)
            OP_ADD:  alu_carry = sum_ext[DATA_W];
            OP_SUB:  alu_carry = a_lt_b;
            default: alu_carry = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Zflag <= 1'b0;
            Cflag <= 1'b0;
        end else if (g_we) begin
            Zflag <= (alu_result == '0);
            Cflag <= alu_carry;
        end
    end
`else
    assign add_result = reg_a + BusWires;
`endif

    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD:  alu_result = add_result;
            OP_SUB:  alu_result = reg_a - BusWires;
            OP_AND:  alu_result = reg_a & BusWires;
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, a_lt_b};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ir    <= '0;
            reg_a <= '0;
            reg_g <= '0;
        end else begin
            if (ir_we) ir    <= DIN[IR_W-1:0];
            if (a_we)  reg_a <= BusWires;
            if (g_we)  reg_g <= alu_result;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (r_we) begin
            regs[rx] <= BusWires;
        end
    end

    assign Rx_data = regs[rx];
    assign Ry_data = regs[ry];

endmodule

// File: tb/tb_processador_multiciclo_gen.sv
// tb/tb_processador_multiciclo_gen.sv - randomized bench with behavioural ISA model for processador_multiciclo_gen
module tb_processador_multiciclo_gen;
    localparam int DW   = 16;
    localparam int RW   = 3;
    localparam int IR_W = 3 + 2 * RW;

    localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] MVNZ = 3'b100, ANDOP = 3'b101, SLT = 3'b110, NOP = 3'b111;

    logic          Clock;
    logic          Resetn;
    logic          Run;
    logic [DW-1:0] DIN;
    logic          Done;
    logic [DW-1:0] BusWires;
    logic [DW-1:0] Rx_data;
    logic [DW-1:0] Ry_data;

    logic          run8;
    logic [7:0]    din8;
    logic          done8;
    logic [7:0]    bus8;
    logic [7:0]    rx8;
    logic [7:0]    ry8;

`ifdef PROC_FLAGS_EN
    logic Zflag, Cflag, z8, c8;
`endif

    processador_multiciclo_gen #(.DATA_W(DW), .RSEL_W(RW)) dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .Done(Done),
        .BusWires(BusWires), .Rx_data(Rx_data), .Ry_data(Ry_data)
`ifdef PROC_FLAGS_EN
        , .Zflag(Zflag), .Cflag(Cflag)
`endif
    );

    processador_multiciclo_gen #(.DATA_W(8), .RSEL_W(2)) dut8 (
        .Clock(Clock), .Resetn(Resetn), .Run(run8), .DIN(din8), .Done(done8),
        .BusWires(bus8), .Rx_data(rx8), .Ry_data(ry8)
`ifdef PROC_FLAGS_EN
        , .Zflag(z8), .Cflag(c8)
`endif
    );

    // Architectural model: register contents, G, flags and the IR register selects.
    logic [DW-1:0] mreg [8];
    logic [DW-1:0] mg;
    logic          mz, mc;
    int            m_rx, m_ry;

    logic          chk_en;
    logic          exp_done;
    logic [DW-1:0] exp_bus;

    int n_chk  = 0;
    int n_pass = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("done", 64'(Done), 64'(exp_done));
            chk("buswires", 64'(BusWires), 64'(exp_bus));
            chk("rx_data", 64'(Rx_data), 64'(mreg[m_rx]));
            chk("ry_data", 64'(Ry_data), 64'(mreg[m_ry]));
`ifdef PROC_FLAGS_EN
            chk("zflag", 64'(Zflag), 64'(mz));
            chk("cflag", 64'(Cflag), 64'(mc));
`endif
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = '0;
        mg = '0; mz = 1'b0; mc = 1'b0;
        m_rx = 0; m_ry = 0;
    endtask

    // Entered and left at 1 time unit after a rising edge, in T0.
    task automatic idle();
        Run = 1'b0; DIN = DW'($urandom);
        exp_bus = '0; exp_done = 1'b0;
        @(posedge Clock); #1;
    endtask

    task automatic run_instr(input logic [2:0] op, input int rx, input int ry, input logic [DW-1:0] imm);
        logic [DW-1:0] din, a, b, res;
        logic [DW:0]   wide;
        logic          c;
        din = DW'($urandom);
        din[IR_W-1:0] = {op, RW'(rx), RW'(ry)};
        Run = 1'b1; DIN = din; exp_bus = '0; exp_done = 1'b0;
        @(posedge Clock);
        m_rx = rx; m_ry = ry;
        #1;
        Run = 1'($urandom);
        DIN = (op == MVI) ? imm : DW'($urandom);
        case (op)
            MV, MVI, MVNZ: begin
                exp_bus  = (op == MVI) ? imm : mreg[ry];
                exp_done = 1'b1;
                @(posedge Clock);
                if (op != MVNZ || mg != '0) mreg[rx] = exp_bus;
            end
            NOP: begin
                exp_bus = '0; exp_done = 1'b1;
                @(posedge Clock);
            end
            default: begin
                exp_bus = mreg[rx]; exp_done = 1'b0;
                @(posedge Clock);
                a = mreg[rx];
                #1;
                Run = 1'($urandom); DIN = DW'($urandom);
                exp_bus = mreg[ry];
                @(posedge Clock);
                b = mreg[ry];
                c = 1'b0;
                case (op)
                    ADD: begin wide = a + b; res = wide[DW-1:0]; c = wide[DW]; end
                    SUB: begin res = a - b; c = (a < b); end
                    ANDOP: res = a & b;
                    default: res = (a < b) ? DW'(1) : DW'(0);
                endcase
                mg = res; mz = (res == '0); mc = c;
                #1;
                Run = 1'($urandom); DIN = DW'($urandom);
                exp_bus = mg; exp_done = 1'b1;
                @(posedge Clock);
                mreg[rx] = mg;
            end
        endcase
        #1;
        Run = 1'b0; DIN = DW'($urandom); exp_bus = '0; exp_done = 1'b0;
    endtask

    task automatic instr8(input logic [2:0] op, input int rx, input int ry, input logic [7:0] imm);
        int k;
        din8 = {1'($urandom), op, 2'(rx), 2'(ry)};
        run8 = 1'b1;
        @(posedge Clock); #1;
        run8 = 1'b0; din8 = imm;
        k = 0;
        while (!done8 && k < 5) begin
            @(posedge Clock); #1;
            k++;
        end
        chk("latency8", 64'(k), (op == MV || op == MVI || op == MVNZ || op == NOP) ? 64'd0 : 64'd2);
        @(posedge Clock); #1;
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b0; DIN = '0; run8 = 1'b0; din8 = '0;
        chk_en = 1'b0; exp_bus = '0; exp_done = 1'b0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_bus", 64'(BusWires), 64'd0);
        chk("reset_rx", 64'(Rx_data), 64'd0);
        chk("reset_ry", 64'(Ry_data), 64'd0);
        chk("reset_done8", 64'(done8), 64'd0);
        Resetn = 1'b1;
        chk_en = 1'b1;
        idle();

        run_instr(MVI, 1, 0, 16'd10);
        run_instr(MVI, 0, 0, 16'd11);
        repeat (3) idle();
        run_instr(MV, 0, 1, '0);
        chk("model_mv_r0", 64'(mreg[0]), 64'd10);
        chk("mv_r0", 64'(Rx_data), 64'd10);
        chk("mv_r1", 64'(Ry_data), 64'd10);
        run_instr(MVI, 0, 0, 16'd5);
        chk("mvi_r0", 64'(Rx_data), 64'd5);
        run_instr(SUB, 1, 0, '0);
        chk("sub_10_5", 64'(Rx_data), 64'd5);
        run_instr(MVI, 0, 0, 16'd10);
        run_instr(SUB, 1, 0, '0);
        chk("model_sub_neg", 64'(mreg[1]), 64'hFFFB);
        chk("sub_5_10", 64'(Rx_data), 64'hFFFB);
`ifdef PROC_FLAGS_EN
        chk("sub_borrow_c", 64'(Cflag), 64'd1);
        chk("sub_borrow_z", 64'(Zflag), 64'd0);
`endif
        run_instr(MVI, 0, 0, 16'd11);
        run_instr(MVI, 1, 0, 16'd10);
        run_instr(SUB, 2, 2, '0);
        chk("sub_self", 64'(Rx_data), 64'd0);
        run_instr(MVNZ, 0, 1, '0);
        chk("mvnz_g0", 64'(Rx_data), 64'd11);
        run_instr(MVI, 2, 0, 16'd15);
        run_instr(MVI, 3, 0, 16'd10);
        run_instr(SUB, 2, 3, '0);
        run_instr(MVNZ, 0, 1, '0);
        chk("mvnz_g5", 64'(Rx_data), 64'd10);
        run_instr(MVI, 2, 0, 16'd3);
        run_instr(MVI, 3, 0, 16'd7);
        run_instr(SLT, 2, 3, '0);
        chk("slt_3_7", 64'(Rx_data), 64'd1);
        run_instr(MV, 2, 2, '0);
        chk("mv_self", 64'(Rx_data), 64'd1);
        run_instr(NOP, 5, 6, '0);

        // Reset asserted between edges while an add sits in T2.
        Run = 1'b1; DIN = {{(DW-IR_W){1'b0}}, ADD, 3'd1, 3'd0};
        @(posedge Clock);
        m_rx = 1; m_ry = 0;
        #1;
        Run = 1'b0; exp_bus = mreg[1]; exp_done = 1'b0;
        @(posedge Clock); #1;
        chk_en = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_bus", 64'(BusWires), 64'd0);
        chk("rst_mid_done", 64'(Done), 64'd0);
        chk("rst_mid_rx", 64'(Rx_data), 64'd0);
        @(posedge Clock); #2;
        Resetn = 1'b1;
        exp_bus = '0; exp_done = 1'b0;
        @(posedge Clock); #1;
        chk_en = 1'b1;
        idle();
        run_instr(MV, 1, 1, '0);
        chk("rst_no_write", 64'(Rx_data), 64'd0);

        for (int n = 0; n < 400; n++) begin
            run_instr(3'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), DW'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
        end

        instr8(MVI, 3, 0, 8'd200);
        instr8(MVI, 2, 0, 8'd100);
        instr8(ADD, 3, 2, 8'h00);
        chk("add8_r3", 64'(rx8), 64'd44);
        chk("add8_r2", 64'(ry8), 64'd100);
`ifdef PROC_FLAGS_EN
        chk("add8_c", 64'(c8), 64'd1);
        chk("add8_z", 64'(z8), 64'd0);
`endif
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
